tx_frame_scheduler: RTL and testbench
=====================================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 Parameter DATA_W, 16, width of user data word.
REQ-002 Parameter CC_PERIOD, 5000, clock cycles between clock-compensation (CC) requests.
REQ-003 Parameter CC_LEN, 6, cycles per CC sequence.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 channel_up  in  1  lane/channel ready; low means the channel is down.
REQ-007 tx_data  in  DATA_W  user word.
REQ-008 tx_valid  in  1  tx_data valid.
REQ-009 tx_last  in  1  final word of frame, qualified by tx_valid.
REQ-010 tx_ready  out  1  word accepted when tx_valid&tx_ready.
REQ-011 send_idle  out  1  emit idle ordered set; drives idle generator send_idle.
REQ-012 send_scp  out  1  emit start-of-frame.
REQ-013 send_ecp  out  1  emit end-of-frame.
REQ-014 send_cc  out  1  emit CC sequence.
REQ-015 data_out  out  DATA_W  transmitted word.
REQ-016 data_valid  out  1  data_out valid.

Function
REQ-017 States: DOWN, IDLE, DATA, ECP, CC; per-cycle action decided from state and inputs, registered to outputs (action in cycle t visible in t+1).
REQ-018 At most one of send_idle/send_scp/send_ecp/send_cc/data_valid high per cycle; exactly one when previous cycle was not DOWN.
REQ-019 tx_ready = (state==DATA) & !cc_pending, combinational; high in no other state.
REQ-020 DOWN: no action; channel_up high -> IDLE.
REQ-021 IDLE: cc_pending -> action CC, go CC; else tx_valid -> action SCP, go DATA (word not consumed); else action IDLE.
REQ-022 DATA: cc_pending -> action CC, go CC, return state DATA; else handshake -> action DATA (data_out<=tx_data), tx_last -> go ECP; else action IDLE (in-frame idle), stay.
REQ-023 ECP: action ECP, go IDLE; cc_pending ignored for this single cycle.
REQ-024 CC: action CC for exactly CC_LEN consecutive cycles, then resume saved return state (IDLE or DATA); tx_ready low throughout.
REQ-025 CC timer: counts while channel_up, reloads CC_PERIOD-1 at zero and sets cc_pending; cc_pending cleared on CC entry; expiry while pending or in CC does not queue a second request.
REQ-026 channel_up low in any state: next state DOWN, frame in progress abandoned (no ECP), cc_pending cleared, timer reloaded; outputs all low from the following cycle.
REQ-027 data_out holds last value when data_valid low.
REQ-028 Elaboration error if CC_LEN<1 or CC_PERIOD<=CC_LEN+2.

Reset
REQ-029 rst high: state DOWN, all outputs 0, data_out 0, cc_pending 0, timer CC_PERIOD-1; effect immediate, independent of clk.
REQ-030 rst mid-frame or mid-CC: frame dropped, no ECP or remaining CC cycles emitted after release.

Configuration
REQ-031 TX_FRAME_SCHEDULER_CC_EN defined: CC timer and CC state present per REQ-024/025.
REQ-032 Undefined: no timer, cc_pending constant 0, send_cc tied 0, CC state absent; CC_PERIOD/CC_LEN unused.

Structure
REQ-033 Shared package aurora_pkg holds the scheduler state enum and default CC_PERIOD/CC_LEN constants.
REQ-034 CC timer is sub-module cc_timer (period counter plus pending flag), instantiated only under the macro.

Verification (CC_PERIOD=20, CC_LEN=3, macro defined unless stated)
REQ-035 Reset release, channel_up=1, tx_valid=0 -> send_idle every cycle; first send_cc burst of 3 cycles starting ~20 cycles after channel_up, repeating every 20.
REQ-036 Frame 4 words A1..A4, tx_valid held -> SCP, A1, A2, A3, A4, ECP on consecutive cycles, tx_ready high 4 cycles.
REQ-037 CC expiry during frame word 2 -> data_out A1, then 3 send_cc, then A2..A4, ECP; no word lost or duplicated.
REQ-038 tx_valid drops for 2 cycles mid-frame -> 2 send_idle between data words, no ECP.
REQ-039 channel_up low after 2 words -> all outputs 0 next cycle, no ECP; channel_up restored -> idles, new frame starts with SCP.
REQ-040 Macro undefined, 100 idle cycles -> send_cc never asserted.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared scheduler types and default clock-compensation timing for the TX frame path.
package aurora_pkg;

  typedef enum logic [2:0] {
    ST_DOWN = 3'd0,
    ST_IDLE = 3'd1,
    ST_DATA = 3'd2,
    ST_ECP  = 3'd3,
    ST_CC   = 3'd4
  } sched_state_t;

  // One action per cycle; registered onto the send_* / data_valid outputs.
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_IDLE = 3'd1,
    ACT_SCP  = 3'd2,
    ACT_DATA = 3'd3,
    ACT_ECP  = 3'd4,
    ACT_CC   = 3'd5
  } sched_act_t;

  localparam int unsigned CC_PERIOD_DEFAULT = 5000;
  localparam int unsigned CC_LEN_DEFAULT    = 6;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cc_timer.sv
// Clock-compensation period timer: down-counter with terminal-count reload and a
// single-entry pending flag that is cleared when the scheduler starts a CC burst.
module cc_timer
  import aurora_pkg::*;
#(
  parameter int unsigned CC_PERIOD = CC_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic in_cc,
  output logic pending
);

  localparam int unsigned CNT_W = cnt_width(CC_PERIOD - 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CC_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= RELOAD;
      pending <= 1'b0;
    end else if (!enable) begin
      cnt     <= RELOAD;
      pending <= 1'b0;
    end else begin
      if (cnt == '0) begin
        cnt <= RELOAD;
        // An expiry that lands on an outstanding or running CC is dropped, not queued.
        if (!pending && !in_cc && !clear) begin
          pending <= 1'b1;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
      if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// TX frame scheduler: frames user words with SCP/ECP, fills gaps with idles and
// inserts periodic CC bursts when TX_FRAME_SCHEDULER_CC_EN is defined.
module tx_frame_scheduler
  import aurora_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CC_PERIOD = CC_PERIOD_DEFAULT,
  parameter int unsigned CC_LEN    = CC_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              channel_up,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              send_idle,
  output logic              send_scp,
  output logic              send_ecp,
  output logic              send_cc,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  if (CC_LEN < 1 || CC_PERIOD <= CC_LEN + 2) begin : g_bad_cfg
    $error("tx_frame_scheduler: need CC_LEN >= 1 and CC_PERIOD > CC_LEN + 2");
  end

  sched_state_t state, state_nxt;
  sched_act_t   act;
  logic         cc_pending;
  logic         cc_enter;

  assign tx_ready = (state == ST_DATA) && !cc_pending;

`ifdef TX_FRAME_SCHEDULER_CC_EN
  localparam int unsigned CC_CNT_W = cnt_width(CC_LEN - 1);

  sched_state_t        ret_state, ret_state_nxt;
  logic [CC_CNT_W-1:0] cc_cnt, cc_cnt_nxt;

  cc_timer #(
    .CC_PERIOD(CC_PERIOD)
  ) u_cc_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (channel_up),
    .clear  (cc_enter),
    .in_cc  (state == ST_CC),
    .pending(cc_pending)
  );
`else
  assign cc_pending = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    act       = ACT_NONE;
    cc_enter  = 1'b0;
`ifdef TX_FRAME_SCHEDULER_CC_EN
    ret_state_nxt = ret_state;
    cc_cnt_nxt    = cc_cnt;
`endif
    if (!channel_up) begin
      state_nxt = ST_DOWN;
    end else begin
      case (state)
        ST_DOWN: state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (cc_pending) begin
            cc_enter = 1'b1;
          end else if (tx_valid) begin
            act       = ACT_SCP;
            state_nxt = ST_DATA;
          end else begin
            act = ACT_IDLE;
          end
        end
        ST_DATA: begin
          // With no CC pending tx_ready is high here, so tx_valid is the handshake.
          if (cc_pending) begin
            cc_enter = 1'b1;
          end else if (tx_valid) begin
            act = ACT_DATA;
            if (tx_last) begin
              state_nxt = ST_ECP;
            end
          end else begin
            act = ACT_IDLE;
          end
        end
        ST_ECP: begin
          act       = ACT_ECP;
          state_nxt = ST_IDLE;
        end
`ifdef TX_FRAME_SCHEDULER_CC_EN
        ST_CC: begin
          act = ACT_CC;
          if (cc_cnt <= CC_CNT_W'(1)) begin
            state_nxt = ret_state;
          end else begin
            cc_cnt_nxt = cc_cnt - CC_CNT_W'(1);
          end
        end
`endif
        default: state_nxt = ST_DOWN;
      endcase
    end

    // The entry cycle already emits the first CC word; CC state covers the rest.
    if (cc_enter) begin
      act = ACT_CC;
`ifdef TX_FRAME_SCHEDULER_CC_EN
      ret_state_nxt = state;
      cc_cnt_nxt    = CC_CNT_W'(CC_LEN - 1);
      state_nxt     = (CC_LEN > 1) ? ST_CC : state;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_DOWN;
      send_idle  <= 1'b0;
      send_scp   <= 1'b0;
      send_ecp   <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_nxt;
      send_idle  <= (act == ACT_IDLE);
      send_scp   <= (act == ACT_SCP);
      send_ecp   <= (act == ACT_ECP);
      data_valid <= (act == ACT_DATA);
      if (act == ACT_DATA) begin
        data_out <= tx_data;
      end
    end
  end

`ifdef TX_FRAME_SCHEDULER_CC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_cc   <= 1'b0;
      ret_state <= ST_IDLE;
      cc_cnt    <= '0;
    end else begin
      send_cc   <= (act == ACT_CC);
      ret_state <= ret_state_nxt;
      cc_cnt    <= cc_cnt_nxt;
    end
  end
`else
  assign send_cc = 1'b0;
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler; CC checks apply when TX_FRAME_SCHEDULER_CC_EN is defined.
module tb_tx_frame_scheduler;

  localparam int DATA_W = 16;
`ifdef TX_FRAME_SCHEDULER_CC_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif
  localparam int IDLE_RUN = CC_ON ? 65 : 100;

  // {send_idle, send_scp, send_ecp, send_cc, data_valid}
  localparam logic [4:0] A_NONE = 5'b00000;
  localparam logic [4:0] A_IDLE = 5'b10000;
  localparam logic [4:0] A_SCP  = 5'b01000;
  localparam logic [4:0] A_ECP  = 5'b00100;
  localparam logic [4:0] A_CC   = 5'b00010;
  localparam logic [4:0] A_DAT  = 5'b00001;

  logic              clk;
  logic              rst;
  logic              channel_up;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;
  logic              send_idle;
  logic              send_scp;
  logic              send_ecp;
  logic              send_cc;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [4:0]        flags;

  int checks = 0;
  int errors = 0;

  assign flags = {send_idle, send_scp, send_ecp, send_cc, data_valid};

  tx_frame_scheduler #(
    .DATA_W   (DATA_W),
    .CC_PERIOD(20),
    .CC_LEN   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .channel_up(channel_up),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .send_idle (send_idle),
    .send_scp  (send_scp),
    .send_ecp  (send_ecp),
    .send_cc   (send_cc),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_act(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed flags %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed data %h expected %h", tag, obs, exp);
    end
  endtask

  // j = steps since channel_up rose; CC timer (period 20) expires at step 20, burst shows on 21..23.
  function automatic logic [4:0] idle_exp(input int j);
    if (j == 1) return A_NONE;
    if (CC_ON && j >= 21 && (j % 20) >= 1 && (j % 20) <= 3) return A_CC;
    return A_IDLE;
  endfunction

  // Drop the channel to restart the timer from a known point; channel_up rises for the next cycle.
  task automatic bring_up();
    channel_up = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    step();
    step();
    chk_act("bringup_down", flags, A_NONE);
    channel_up = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    channel_up = 1'b0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    tx_data    = '0;
    step();
    step();
    chk_act("reset_flags", flags, A_NONE);
    chk_data("reset_data", data_out, 16'h0000);
    chk_bit("reset_ready", tx_ready, 1'b0);

    // Idle stream with periodic CC bursts
    rst        = 1'b0;
    channel_up = 1'b1;
    for (int j = 1; j <= IDLE_RUN; j++) begin
      step();
      chk_act($sformatf("idle_run_%0d", j), flags, idle_exp(j));
    end

    // Four-word frame with tx_valid held
    bring_up();
    step();  chk_act("a_down", flags, A_NONE); chk_bit("a_ready_idle", tx_ready, 1'b0);
    tx_valid = 1'b1; tx_data = 16'hA001;
    step();  chk_act("a_scp", flags, A_SCP); chk_bit("a_ready_1", tx_ready, 1'b1);
    step();  chk_act("a_w1", flags, A_DAT); chk_data("a_d1", data_out, 16'hA001);
    chk_bit("a_ready_2", tx_ready, 1'b1);
    tx_data = 16'hA002;
    step();  chk_act("a_w2", flags, A_DAT); chk_data("a_d2", data_out, 16'hA002);
    chk_bit("a_ready_3", tx_ready, 1'b1);
    tx_data = 16'hA003;
    step();  chk_act("a_w3", flags, A_DAT); chk_data("a_d3", data_out, 16'hA003);
    chk_bit("a_ready_4", tx_ready, 1'b1);
    tx_data = 16'hA004; tx_last = 1'b1;
    step();  chk_act("a_w4", flags, A_DAT); chk_data("a_d4", data_out, 16'hA004);
    chk_bit("a_ready_ecp", tx_ready, 1'b0);
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 16'h5555;
    step();  chk_act("a_ecp", flags, A_ECP);
    step();  chk_act("a_idle", flags, A_IDLE); chk_data("a_hold", data_out, 16'hA004);

    // Two-cycle valid gap inside a frame
    tx_valid = 1'b1; tx_data = 16'hB001;
    step();  chk_act("b_scp", flags, A_SCP);
    step();  chk_act("b_w1", flags, A_DAT); chk_data("b_d1", data_out, 16'hB001);
    tx_valid = 1'b0;
    step();  chk_act("b_gap1", flags, A_IDLE); chk_bit("b_ready_gap", tx_ready, 1'b1);
    step();  chk_act("b_gap2", flags, A_IDLE); chk_data("b_hold", data_out, 16'hB001);
    tx_valid = 1'b1; tx_data = 16'hB002; tx_last = 1'b1;
    step();  chk_act("b_w2", flags, A_DAT); chk_data("b_d2", data_out, 16'hB002);
    tx_valid = 1'b0; tx_last = 1'b0;
    step();  chk_act("b_ecp", flags, A_ECP);
    step();  chk_act("b_idle", flags, A_IDLE);

`ifdef TX_FRAME_SCHEDULER_CC_EN
    // CC request lands on the second word of a frame
    bring_up();
    for (int j = 1; j <= 18; j++) begin
      step();
      chk_act($sformatf("c_pre_%0d", j), flags, idle_exp(j));
    end
    tx_valid = 1'b1; tx_data = 16'hC001;
    step();  chk_act("c_scp", flags, A_SCP);
    step();  chk_act("c_w1", flags, A_DAT); chk_data("c_d1", data_out, 16'hC001);
    chk_bit("c_ready_pend", tx_ready, 1'b0);
    tx_data = 16'hC002;
    step();  chk_act("c_cc1", flags, A_CC); chk_bit("c_ready_cc", tx_ready, 1'b0);
    step();  chk_act("c_cc2", flags, A_CC); chk_data("c_hold", data_out, 16'hC001);
    step();  chk_act("c_cc3", flags, A_CC); chk_bit("c_ready_back", tx_ready, 1'b1);
    step();  chk_act("c_w2", flags, A_DAT); chk_data("c_d2", data_out, 16'hC002);
    tx_data = 16'hC003;
    step();  chk_act("c_w3", flags, A_DAT); chk_data("c_d3", data_out, 16'hC003);
    tx_data = 16'hC004; tx_last = 1'b1;
    step();  chk_act("c_w4", flags, A_DAT); chk_data("c_d4", data_out, 16'hC004);
    tx_valid = 1'b0; tx_last = 1'b0;
    step();  chk_act("c_ecp", flags, A_ECP);
    step();  chk_act("c_idle", flags, A_IDLE);
`endif

    // Channel drops after two words, then recovers
    bring_up();
    step();  chk_act("d_down", flags, A_NONE);
    tx_valid = 1'b1; tx_data = 16'hD001;
    step();  chk_act("d_scp", flags, A_SCP);
    step();  chk_act("d_w1", flags, A_DAT); chk_data("d_d1", data_out, 16'hD001);
    tx_data = 16'hD002;
    step();  chk_act("d_w2", flags, A_DAT); chk_data("d_d2", data_out, 16'hD002);
    tx_data = 16'hD003; channel_up = 1'b0;
    step();  chk_act("d_lost1", flags, A_NONE);
    step();  chk_act("d_lost2", flags, A_NONE); chk_bit("d_ready_down", tx_ready, 1'b0);
    channel_up = 1'b1; tx_valid = 1'b0;
    step();  chk_act("d_up_down", flags, A_NONE);
    step();  chk_act("d_up_idle", flags, A_IDLE);
    tx_valid = 1'b1; tx_data = 16'hD101;
    step();  chk_act("d_new_scp", flags, A_SCP);
    step();  chk_act("d_new_w1", flags, A_DAT); chk_data("d_new_d1", data_out, 16'hD101);

    // Asynchronous reset in the middle of a frame
    bring_up();
    step();  chk_act("e_down", flags, A_NONE);
    tx_valid = 1'b1; tx_data = 16'hE001;
    step();  chk_act("e_scp", flags, A_SCP);
    step();  chk_act("e_w1", flags, A_DAT);
    rst = 1'b1;
    #2;
    chk_act("e_async_flags", flags, A_NONE);
    chk_data("e_async_data", data_out, 16'h0000);
    chk_bit("e_async_ready", tx_ready, 1'b0);
    step();
    rst = 1'b0; tx_valid = 1'b0;
    step();  chk_act("e_rel_down", flags, A_NONE);
    step();  chk_act("e_rel_idle1", flags, A_IDLE);
    step();  chk_act("e_rel_idle2", flags, A_IDLE);

`ifdef TX_FRAME_SCHEDULER_CC_EN
    // Asynchronous reset in the middle of a CC burst
    bring_up();
    for (int j = 1; j <= 22; j++) begin
      step();
      chk_act($sformatf("f_pre_%0d", j), flags, idle_exp(j));
    end
    rst = 1'b1;
    #2;
    chk_act("f_async_flags", flags, A_NONE);
    step();
    rst = 1'b0;
    step();  chk_act("f_rel_down", flags, A_NONE);
    step();  chk_act("f_rel_idle1", flags, A_IDLE);
    step();  chk_act("f_rel_idle2", flags, A_IDLE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
